// File: rtl/multicycle_control_fsm.sv
// Multicycle core controller: Moore sequencer plus embedded ALU decoder driving ALUControl.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap into a sticky ERROR state.
module multicycle_control_fsm #(
    parameter int ALUCTRL_W = 3,
    parameter int MEM_WAIT  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           state,
    output logic                 illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b000);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b001);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b010);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b011);
    localparam logic [ALUCTRL_W-1:0] ALU_NOP = ALUCTRL_W'(3'b100);

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wait_done;
    logic       pc_update, branch, ir_write, reg_write, mem_write;
    alu_op_t    alu_op;

    assign wait_done = (cnt_q == WAIT_MAX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (wait_done) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = S_ERROR;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (wait_done) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_FETCH;
        endcase

        // Counter restarts on every state entry and parks at MEM_WAIT
        if (state_d != state_q)  cnt_d = 4'd0;
        else if (!wait_done)     cnt_d = cnt_q + 4'd1;
        else                     cnt_d = cnt_q;
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = wait_done;
                pc_update = wait_done;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_NOP;
                endcase
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Enables are masked while reset is high so an aborted instruction commits nothing
    assign PCWrite  = ~reset & (pc_update | (branch & Zero));
    assign IRWrite  = ~reset & ir_write;
    assign RegWrite = ~reset & reg_write;
    assign MemWrite = ~reset & mem_write;
    assign state    = state_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_ERROR);
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: instance 0 with MEM_WAIT=0, instance 1 with MEM_WAIT=2.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       pcw_w [2];
    logic       adr_w [2];
    logic       mw_w  [2];
    logic       irw_w [2];
    logic       rw_w  [2];
    logic [1:0] res_w [2];
    logic [1:0] sa_w  [2];
    logic [1:0] sb_w  [2];
    logic [1:0] imm_w [2];
    logic [2:0] alu_w [2];
    logic [3:0] st_w  [2];
    logic       ill_w [2];

    always #5 clk = ~clk;

    multicycle_control_fsm #(.ALUCTRL_W(3), .MEM_WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
        .PCWrite(pcw_w[0]), .AdrSrc(adr_w[0]), .MemWrite(mw_w[0]), .IRWrite(irw_w[0]),
        .RegWrite(rw_w[0]), .ResultSrc(res_w[0]), .ALUSrcA(sa_w[0]), .ALUSrcB(sb_w[0]),
        .ImmSrc(imm_w[0]), .ALUControl(alu_w[0]), .state(st_w[0]), .illegal(ill_w[0])
    );

    multicycle_control_fsm #(.ALUCTRL_W(3), .MEM_WAIT(2)) u_dut1 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
        .PCWrite(pcw_w[1]), .AdrSrc(adr_w[1]), .MemWrite(mw_w[1]), .IRWrite(irw_w[1]),
        .RegWrite(rw_w[1]), .ResultSrc(res_w[1]), .ALUSrcA(sa_w[1]), .ALUSrcB(sb_w[1]),
        .ImmSrc(imm_w[1]), .ALUControl(alu_w[1]), .state(st_w[1]), .illegal(ill_w[1])
    );

    typedef struct packed {
        logic       dut;
        logic [3:0] st;
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mw;
        logic       ca;
        logic [2:0] alu;
        logic       ill;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    task automatic check(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    // Monitor: every cycle, compare the DUT outputs against what the stimulus queued for it
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("dut%0d state", e.dut), cyc_no, st_w[e.dut], e.st);
            check($sformatf("dut%0d PCWrite", e.dut), cyc_no, {3'b0, pcw_w[e.dut]}, {3'b0, e.pcw});
            check($sformatf("dut%0d IRWrite", e.dut), cyc_no, {3'b0, irw_w[e.dut]}, {3'b0, e.irw});
            check($sformatf("dut%0d RegWrite", e.dut), cyc_no, {3'b0, rw_w[e.dut]}, {3'b0, e.rw});
            check($sformatf("dut%0d MemWrite", e.dut), cyc_no, {3'b0, mw_w[e.dut]}, {3'b0, e.mw});
            check($sformatf("dut%0d illegal", e.dut), cyc_no, {3'b0, ill_w[e.dut]}, {3'b0, e.ill});
            if (e.ca)
                check($sformatf("dut%0d ALUControl", e.dut), cyc_no, {1'b0, alu_w[e.dut]}, {1'b0, e.alu});
        end
    end

    task automatic cyc(input logic d, input logic [3:0] s, input logic pcw, input logic irw,
                       input logic rw, input logic mw, input logic ca, input logic [2:0] alu,
                       input logic ill);
        exp_t e;
        e = '{dut: d, st: s, pcw: pcw, irw: irw, rw: rw, mw: mw, ca: ca, alu: alu, ill: ill};
        sb_q.push_back(e);
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch0();
        cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0);
    endtask

    task automatic decode0();
        cyc(1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
        tick();
        // Two reset cycles: FETCH, enables masked
        cyc(0, 4'd0, 0, 0, 0, 0, 1, 3'b010, 0);
        cyc(0, 4'd0, 0, 0, 0, 0, 1, 3'b010, 0);
        reset = 1'b0;

        // R-type sub, then add
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        fetch0(); decode0();
        cyc(0, 4'd6, 0, 0, 0, 0, 1, 3'b011, 0);
        cyc(0, 4'd8, 0, 0, 1, 0, 0, 3'b000, 0);
        funct7b5 = 1'b0;
        fetch0(); decode0();
        cyc(0, 4'd6, 0, 0, 0, 0, 1, 3'b010, 0);
        cyc(0, 4'd8, 0, 0, 1, 0, 0, 3'b000, 0);

        // I-type: funct7b5 ignored for immediates, then NOP/OR/AND decodes
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        fetch0(); decode0();
        cyc(0, 4'd7, 0, 0, 0, 0, 1, 3'b010, 0);
        cyc(0, 4'd8, 0, 0, 1, 0, 0, 3'b000, 0);
        funct3 = 3'b010; funct7b5 = 1'b0;
        fetch0(); decode0();
        cyc(0, 4'd7, 0, 0, 0, 0, 1, 3'b100, 0);
        cyc(0, 4'd8, 0, 0, 1, 0, 0, 3'b000, 0);
        funct3 = 3'b110;
        fetch0(); decode0();
        cyc(0, 4'd7, 0, 0, 0, 0, 1, 3'b001, 0);
        cyc(0, 4'd8, 0, 0, 1, 0, 0, 3'b000, 0);
        funct3 = 3'b111;
        fetch0(); decode0();
        cyc(0, 4'd7, 0, 0, 0, 0, 1, 3'b000, 0);
        cyc(0, 4'd8, 0, 0, 1, 0, 0, 3'b000, 0);

        // beq taken / not taken
        op = 7'b1100011; zero = 1'b1;
        fetch0(); decode0();
        cyc(0, 4'd9, 1, 0, 0, 0, 1, 3'b011, 0);
        zero = 1'b0;
        fetch0(); decode0();
        cyc(0, 4'd9, 0, 0, 0, 0, 1, 3'b011, 0);

        // lw, sw, jal
        op = 7'b0000011;
        fetch0(); decode0();
        cyc(0, 4'd2, 0, 0, 0, 0, 1, 3'b010, 0);
        cyc(0, 4'd3, 0, 0, 0, 0, 0, 3'b000, 0);
        cyc(0, 4'd4, 0, 0, 1, 0, 0, 3'b000, 0);
        op = 7'b0100011;
        fetch0(); decode0();
        cyc(0, 4'd2, 0, 0, 0, 0, 1, 3'b010, 0);
        cyc(0, 4'd5, 0, 0, 0, 1, 0, 3'b000, 0);
        op = 7'b1101111;
        fetch0(); decode0();
        cyc(0, 4'd10, 1, 0, 0, 0, 1, 3'b010, 0);
        cyc(0, 4'd8, 0, 0, 1, 0, 0, 3'b000, 0);

        // Unknown opcode
        op = 7'b1111111;
        fetch0(); decode0();
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc(0, 4'd11, 0, 0, 0, 0, 0, 3'b000, 1);
        cyc(0, 4'd11, 0, 0, 0, 0, 0, 3'b000, 1);
        cyc(0, 4'd11, 0, 0, 0, 0, 0, 3'b000, 1);
        reset = 1'b1; op = 7'b0000011;
        cyc(0, 4'd11, 0, 0, 0, 0, 0, 3'b000, 1);
        reset = 1'b0;
`else
        op = 7'b0000011;
`endif

        // lw aborted by reset in MEMWB: RegWrite must stay low
        fetch0(); decode0();
        cyc(0, 4'd2, 0, 0, 0, 0, 1, 3'b010, 0);
        cyc(0, 4'd3, 0, 0, 0, 0, 0, 3'b000, 0);
        reset = 1'b1;
        cyc(0, 4'd4, 0, 0, 0, 0, 0, 3'b000, 0);
        reset = 1'b0;
        fetch0();

        // MEM_WAIT=2 instance: lw takes 9 cycles, R-type 6
        reset = 1'b1; op = 7'b0000011;
        tick();
        reset = 1'b0;
        cyc(1, 4'd0, 0, 0, 0, 0, 0, 3'b000, 0);
        cyc(1, 4'd0, 0, 0, 0, 0, 0, 3'b000, 0);
        cyc(1, 4'd0, 1, 1, 0, 0, 1, 3'b010, 0);
        cyc(1, 4'd1, 0, 0, 0, 0, 1, 3'b010, 0);
        cyc(1, 4'd2, 0, 0, 0, 0, 1, 3'b010, 0);
        cyc(1, 4'd3, 0, 0, 0, 0, 0, 3'b000, 0);
        cyc(1, 4'd3, 0, 0, 0, 0, 0, 3'b000, 0);
        cyc(1, 4'd3, 0, 0, 0, 0, 0, 3'b000, 0);
        cyc(1, 4'd4, 0, 0, 1, 0, 0, 3'b000, 0);
        op = 7'b0110011; funct3 = 3'b111;
        cyc(1, 4'd0, 0, 0, 0, 0, 0, 3'b000, 0);
        cyc(1, 4'd0, 0, 0, 0, 0, 0, 3'b000, 0);
        cyc(1, 4'd0, 1, 1, 0, 0, 1, 3'b010, 0);
        cyc(1, 4'd1, 0, 0, 0, 0, 1, 3'b010, 0);
        cyc(1, 4'd6, 0, 0, 0, 0, 1, 3'b000, 0);
        cyc(1, 4'd8, 0, 0, 1, 0, 0, 3'b000, 0);
        cyc(1, 4'd0, 0, 0, 0, 0, 0, 3'b000, 0);

        tick();
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
